// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction-fetch request controller: issues bus requests, tracks outstanding
// responses and discards stale ones. Define IBEX_FETCH_STALL_CNT_EN for the grant-stall counter.
module ibex_fetch_req_ctrl #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                setback_i,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         addr_i,
    input  logic [NUM_REQS-1:0] fifo_busy_i,
    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic                instr_err_i,
    output logic                fifo_clear_o,
    output logic [31:0]         fifo_addr_o,
    output logic                fifo_push_o,
    output logic                busy_o,
    output logic [31:0]         stall_cnt_o
);

    localparam int CW = 3;

    typedef enum logic {
        IDLE,
        WAIT_GNT
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_pop;
    logic [NUM_REQS-1:0] discard_q, discard_d;
    logic                pend_discard_q, pend_discard_d;
    logic [31:0]         fetch_addr_q, fetch_addr_d;
    logic [31:0]         branch_tgt;
    logic [3:0]          busy_cnt;
    logic [3:0]          occupancy;
    logic                gnt;
    logic                new_discard;
    logic                unused_err;

    // Error flag travels to the FIFO alongside rdata, outside this block.
    assign unused_err   = instr_err_i;

    assign branch_tgt   = {addr_i[31:2], 2'b00};
    assign instr_addr_o = branch_i ? branch_tgt : fetch_addr_q;
    assign fifo_clear_o = branch_i | setback_i;
    assign fifo_addr_o  = addr_i;
    assign gnt          = instr_req_o & instr_gnt_i;
    assign busy_o       = instr_req_o | (cnt_q != '0);

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            busy_cnt = busy_cnt + {3'b000, fifo_busy_i[i]};
        end
        occupancy = {1'b0, cnt_q} + (branch_i ? 4'd0 : busy_cnt);
    end

    always_comb begin
        state_d     = state_q;
        instr_req_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_i && !setback_i && (occupancy < 4'(NUM_REQS))) begin
                    instr_req_o = 1'b1;
                    if (!instr_gnt_i) begin
                        state_d = WAIT_GNT;
                    end
                end
            end
            WAIT_GNT: begin
                instr_req_o = 1'b1;
                if (instr_gnt_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A request hit by setback while waiting is still completed on the bus, but its
    // data is stale; a later branch re-targets it and makes it live again.
    assign new_discard    = ~branch_i & (setback_i | pend_discard_q);
    assign pend_discard_d = (state_d == WAIT_GNT) ? new_discard : 1'b0;

    assign cnt_pop     = cnt_q - {2'b00, instr_rvalid_i};
    assign cnt_d       = cnt_pop + {2'b00, gnt};
    assign fifo_push_o = instr_rvalid_i & ~discard_q[0] & ~fifo_clear_o;

    always_comb begin
        discard_d = discard_q;
        if (fifo_clear_o) begin
            discard_d = '1;
        end
        if (instr_rvalid_i) begin
            discard_d = discard_d >> 1;
        end
        if (gnt) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (cnt_pop == CW'(i)) begin
                    discard_d[i] = new_discard;
                end
            end
        end
    end

    // Discarded requests do not advance the PC, so fetch resumes where setback left it.
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        if (branch_i) begin
            fetch_addr_d = gnt ? branch_tgt + 32'd4 : branch_tgt;
        end else if (gnt && !new_discard) begin
            fetch_addr_d = fetch_addr_q + 32'd4;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            discard_q      <= '0;
            pend_discard_q <= 1'b0;
            fetch_addr_q   <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            discard_q      <= discard_d;
            pend_discard_q <= pend_discard_d;
            fetch_addr_q   <= fetch_addr_d;
        end
    end

`ifdef IBEX_FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (instr_req_o && !instr_gnt_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/ibex_fetch_req_ctrl.md
IBEX_FETCH_REQ_CTRL -- requirements
Module: ibex_fetch_req_ctrl

Interface
REQ-001 Parameter NUM_REQS, default 2, is the maximum number of outstanding instruction-bus requests; legal range 1..4.
REQ-002 clk_i  input  1  clock; all flops on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 setback_i  input  1  synchronous lockstep setback; discards in-flight fetch state.
REQ-005 req_i  input  1  fetch enable from core.
REQ-006 branch_i  input  1  redirect fetch to addr_i this cycle.
REQ-007 addr_i  input  32  branch target, halfword aligned.
REQ-008 fifo_busy_i  input  NUM_REQS  upper-entry occupancy from fetch FIFO.
REQ-009 instr_req_o  output  1  bus request.
REQ-010 instr_gnt_i  input  1  bus grant.
REQ-011 instr_addr_o  output  32  bus word address, bits [1:0] always 0.
REQ-012 instr_rvalid_i  input  1  response valid, in request order.
REQ-013 instr_err_i  input  1  response error, qualified by instr_rvalid_i.
REQ-014 fifo_clear_o  output  1  clear fetch FIFO and load fifo_addr_o.
REQ-015 fifo_addr_o  output  32  PC loaded into FIFO on clear.
REQ-016 fifo_push_o  output  1  push current response (rdata/err routed directly to FIFO).
REQ-017 busy_o  output  1  request pending or responses outstanding.
REQ-018 stall_cnt_o  output  32  grant-stall cycle count (see Configuration).

Function
REQ-019 States: IDLE (no unaccepted request), WAIT_GNT (instr_req_o high, not yet granted).
REQ-020 fetch_addr_q holds next word address; on branch_i it loads {addr_i[31:2],2'b00}; on each grant it increments by 4, wrapping 32'hFFFF_FFFC -> 0.
REQ-021 instr_addr_o = branch_i ? {addr_i[31:2],2'b00} : fetch_addr_q.
REQ-022 In IDLE, instr_req_o is asserted when req_i & (outstanding + popcount(fifo_busy_i) < NUM_REQS); when branch_i, the FIFO term counts as 0.
REQ-023 instr_req_o & ~instr_gnt_i moves IDLE->WAIT_GNT; WAIT_GNT holds instr_req_o high regardless of req_i until grant, then returns to IDLE.
REQ-024 In WAIT_GNT, address is stable except on branch_i, which replaces it with the new target in the same cycle.
REQ-025 Outstanding count (0..NUM_REQS) increments on grant, decrements on instr_rvalid_i, unchanged on both; grant SHALL NOT occur at NUM_REQS outstanding.
REQ-026 Per-slot discard flags in FIFO order: branch_i or setback_i marks every outstanding slot discard; a request granted in the branch cycle is not discarded.
REQ-027 On instr_rvalid_i, oldest slot's discard flag set -> response dropped, fifo_push_o=0; clear -> fifo_push_o=1 same cycle (zero latency), errors pushed unchanged.
REQ-028 fifo_clear_o = branch_i | setback_i; fifo_addr_o = addr_i.
REQ-029 setback_i: IDLE and suppresses new request that cycle; WAIT_GNT continues until grant with that response discarded; fetch_addr_q unchanged.
REQ-030 Simultaneous branch_i and setback_i: branch behaviour wins for address, both discard.
REQ-031 busy_o = instr_req_o | (outstanding != 0).

Reset
REQ-032 Reset: state IDLE, outstanding 0, discard flags 0, fetch_addr_q 0, stall counter 0.
REQ-033 Reset outputs: instr_req_o=0, fifo_push_o=0, fifo_clear_o=0, busy_o=0, stall_cnt_o=0.

Configuration
REQ-034 Macro IBEX_FETCH_STALL_CNT_EN defined: stall_cnt_o counts cycles with instr_req_o & ~instr_gnt_i, saturates at 32'hFFFF_FFFF, cleared only by reset.
REQ-035 Macro undefined: no counter flops, stall_cnt_o tied to 0; all other behaviour identical.

Verification
REQ-036 Reset released, req_i=1, gnt always 1, rvalid 1 cycle after gnt -> addresses 0,4,8,... and one fifo_push_o per response.
REQ-037 NUM_REQS=2, gnt=1, rvalid withheld -> exactly 2 grants then instr_req_o=0 until rvalid; busy_o=1 throughout.
REQ-038 gnt=0 for 3 cycles at addr 0x100, req_i dropped -> instr_req_o held, addr 0x100 stable; stall_cnt_o=3 with macro, 0 without.
REQ-039 2 outstanding, branch_i addr_i=0x2002 -> fifo_clear_o=1, instr_addr_o=0x2000, both old responses dropped, first push is 0x2000 data.
REQ-040 setback_i in WAIT_GNT, 1 outstanding -> request held to grant, both responses dropped, fifo_clear_o=1, then fetch resumes at fetch_addr_q.
REQ-041 fetch_addr_q=0xFFFFFFFC granted -> next instr_addr_o=0x00000000.
